// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM encodings and default sizes,
// visible to the control unit for stall decisions.
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/Done handshake bundle between control (master) and the multiplier (slave).
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, in_a, in_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, in_a, in_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/seq_multiplier_twos_negate.sv
// Conditional two's-complement negate: y = en ? -x : x, modulo 2**W.
module twos_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = en ? ('0 - x) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: magnitudes are multiplied over WIDTH iterations, then the
// sign is applied to the 2*WIDTH-bit result in a single fix-up cycle.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_multiplier_if.slave   bus
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   mult_reg, mult_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic               neg_reg, neg_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   operand   [2];
    logic [WIDTH-1:0]   magnitude [2];
    logic [2*WIDTH-1:0] product;

    assign operand[0] = bus.in_a;
    assign operand[1] = bus.in_b;

    // The most negative operand maps onto itself, which is its correct unsigned magnitude.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            twos_negate #(.W(WIDTH)) u_mag (
                .en (bus.is_signed & operand[gi][WIDTH-1]),
                .x  (operand[gi]),
                .y  (magnitude[gi])
            );
        end
    endgenerate

    twos_negate #(.W(2*WIDTH)) u_fix (
        .en (neg_reg),
        .x  ({acc_reg, mult_reg}),
        .y  (product)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        mult_next  = mult_reg;
        mcand_next = mcand_reg;
        neg_next   = neg_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        sum        = '0;

        // Busy covers the Done cycle, so a Start alongside Done is rejected below.
        if (done_reg) begin
            busy_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (bus.start && !busy_reg) begin
                    mcand_next = magnitude[0];
                    mult_next  = magnitude[1];
                    neg_next   = bus.is_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                    acc_next   = '0;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                sum = mult_reg[0] ? ({1'b0, acc_reg} + {1'b0, mcand_reg}) : {1'b0, acc_reg};
                acc_next  = sum[WIDTH:1];
                mult_next = {sum[0], mult_reg[WIDTH-1:1]};
                cnt_next  = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                hi_next    = product[2*WIDTH-1:WIDTH];
                lo_next    = product[WIDTH-1:0];
                done_next  = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            mult_reg  <= '0;
            mcand_reg <= '0;
            neg_reg   <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            mult_reg  <= mult_next;
            mcand_reg <= mcand_next;
            neg_reg   <= neg_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule
